// File: rtl/operand_entry.sv
// rtl/operand_entry.sv - debounced enter/clear buttons load operands A then B from the switch bank
module operand_entry #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] sw,
  input  logic             btn_enter,
  input  logic             btn_clear,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic             a_valid,
  output logic             b_valid,
  output logic             ready
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {WAIT_A, WAIT_B, DONE} state_e;

  // Button chains are vectorised: bit 0 is enter, bit 1 is clear.
  logic [1:0]         raw;
  logic [1:0]         meta_q, meta_d;
  logic [1:0]         sync_q, sync_d;
  logic [1:0]         lvl_q, lvl_d;
  logic [1:0]         lvl_dly_q, lvl_dly_d;
  logic [1:0][CW-1:0] cnt_q, cnt_d;
  logic [1:0]         press;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic               av_q, av_d, bv_q, bv_d;
  logic               ready_q, ready_d;

  assign raw   = {btn_clear, btn_enter};
  assign press = lvl_q & ~lvl_dly_q;

  always_comb begin
    meta_d    = raw;
    sync_d    = meta_q;
    lvl_d     = lvl_q;
    lvl_dly_d = lvl_q;
    cnt_d     = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync_q[i] != lvl_q[i]) begin
        if (cnt_q[i] == CNT_LAST) lvl_d[i] = sync_q[i];
        else cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  // Clear outranks enter when both pulses land in the same cycle.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    av_d    = av_q;
    bv_d    = bv_q;
    if (press[1]) begin
      a_d     = '0;
      b_d     = '0;
      av_d    = 1'b0;
      bv_d    = 1'b0;
      state_d = WAIT_A;
    end else if (press[0]) begin
      case (state_q)
        WAIT_A: begin
          a_d     = sw;
          av_d    = 1'b1;
          state_d = WAIT_B;
        end
        WAIT_B: begin
          b_d     = sw;
          bv_d    = 1'b1;
          state_d = DONE;
        end
        DONE: begin
          a_d     = sw;
          av_d    = 1'b1;
          b_d     = '0;
          bv_d    = 1'b0;
          state_d = WAIT_B;
        end
        default: state_d = WAIT_A;
      endcase
    end
    ready_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta_q    <= '0;
      sync_q    <= '0;
      lvl_q     <= '0;
      lvl_dly_q <= '0;
      cnt_q     <= '0;
      state_q   <= WAIT_A;
      a_q       <= '0;
      b_q       <= '0;
      av_q      <= 1'b0;
      bv_q      <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      meta_q    <= meta_d;
      sync_q    <= sync_d;
      lvl_q     <= lvl_d;
      lvl_dly_q <= lvl_dly_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      av_q      <= av_d;
      bv_q      <= bv_d;
      ready_q   <= ready_d;
    end
  end

  assign A       = a_q;
  assign B       = b_q;
  assign a_valid = av_q;
  assign b_valid = bv_q;
  assign ready   = ready_q;

endmodule
